// File: rtl/lsu_ctrl.sv
// Load/store sequencer: validates an execute-stage memory op, runs a req/ack bus access, extends load data.
// Start-to-done latency is 2 cycles minimum; stall holds the pipeline until done or fault, and memReq waits for memAck up to TIMEOUT cycles.
module lsu_ctrl #(
   parameter int TIMEOUT = 16,
   parameter int XLEN    = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            isStore,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] addr,
   input  logic [XLEN-1:0] storeData,
   output logic            stall,
   output logic            done,
   output logic [XLEN-1:0] loadData,
   output logic            fault,
   output logic [1:0]      faultCause,
   output logic            memReq,
   output logic            memWe,
   output logic [XLEN-1:0] memAddr,
   output logic [XLEN-1:0] memWdata,
   output logic [3:0]      memByteEn,
   input  logic            memAck,
   input  logic [XLEN-1:0] memRdata
);

   typedef enum logic [1:0] {IDLE, REQ, DONE, FAULT} state_t;

   state_t          state, state_nxt;
   logic [7:0]      cnt;
   logic [1:0]      lane;
   logic [2:0]      op_f3;
   logic            illegal, misaligned, timeout_hit;
   logic [3:0]      be_nxt;
   logic [XLEN-1:0] wdata_nxt, ld_ext;
   logic [7:0]      ld_byte;
   logic [15:0]     ld_half;

   always_comb begin
      illegal     = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (isStore && funct3[2]);
      misaligned  = ((funct3[1:0] == 2'b01) && addr[0]) ||
                    ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
      timeout_hit = (cnt == 8'(TIMEOUT - 1));
   end

   // Lane enables and replicated store data, computed from the live request inputs.
   always_comb begin
      case (funct3[1:0])
         2'b00:   begin be_nxt = 4'b0001 << addr[1:0];               wdata_nxt = {4{storeData[7:0]}};  end
         2'b01:   begin be_nxt = addr[1] ? 4'b1100 : 4'b0011;        wdata_nxt = {2{storeData[15:0]}}; end
         default: begin be_nxt = 4'b1111;                            wdata_nxt = storeData;            end
      endcase
   end

   // Load extraction uses the lane and width latched when the request was accepted.
   always_comb begin
      ld_byte = memRdata[{lane, 3'b000} +: 8];
      ld_half = lane[1] ? memRdata[31:16] : memRdata[15:0];
      case (op_f3)
         3'b000:  ld_ext = {{(XLEN-8){ld_byte[7]}}, ld_byte};
         3'b100:  ld_ext = {{(XLEN-8){1'b0}}, ld_byte};
         3'b001:  ld_ext = {{(XLEN-16){ld_half[15]}}, ld_half};
         3'b101:  ld_ext = {{(XLEN-16){1'b0}}, ld_half};
         default: ld_ext = memRdata;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = (illegal || misaligned) ? FAULT : REQ;
         REQ:     if (memAck) state_nxt = DONE;
                  else if (timeout_hit) state_nxt = FAULT;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      stall = ((state == IDLE) && start) || (state == REQ);
      done  = (state == DONE);
      fault = (state == FAULT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         memReq     <= 1'b0;
         memWe      <= 1'b0;
         memAddr    <= '0;
         memWdata   <= '0;
         memByteEn  <= 4'b0000;
         loadData   <= '0;
         faultCause <= 2'b00;
         cnt        <= 8'd0;
         lane       <= 2'b00;
         op_f3      <= 3'b000;
      end else begin
         case (state)
            IDLE: if (start) begin
               if (illegal)         faultCause <= 2'b10;
               else if (misaligned) faultCause <= 2'b01;
               else begin
                  memReq    <= 1'b1;
                  memWe     <= isStore;
                  memAddr   <= {addr[XLEN-1:2], 2'b00};
                  memWdata  <= isStore ? wdata_nxt : '0;
                  memByteEn <= be_nxt;
                  cnt       <= 8'd0;
                  lane      <= addr[1:0];
                  op_f3     <= funct3;
               end
            end
            REQ: begin
               if (memAck) begin
                  memReq <= 1'b0;
                  memWe  <= 1'b0;
                  if (!memWe) loadData <= ld_ext;
               end else if (timeout_hit) begin
                  memReq     <= 1'b0;
                  memWe      <= 1'b0;
                  faultCause <= 2'b11;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl built with TIMEOUT=4; inputs change and outputs are sampled 1-2 ns after each rising edge.
module tb_lsu_ctrl;

   logic        clk, rst, start, isStore, memAck;
   logic [2:0]  funct3;
   logic [31:0] addr, storeData, memRdata, loadData, memAddr, memWdata;
   logic        stall, done, fault, memReq, memWe;
   logic [1:0]  faultCause;
   logic [3:0]  memByteEn;
   int          checks = 0;
   int          failures = 0;

   lsu_ctrl #(.TIMEOUT(4), .XLEN(32)) dut (
      .clk(clk), .rst(rst), .start(start), .isStore(isStore), .funct3(funct3),
      .addr(addr), .storeData(storeData), .stall(stall), .done(done),
      .loadData(loadData), .fault(fault), .faultCause(faultCause),
      .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
      .memByteEn(memByteEn), .memAck(memAck), .memRdata(memRdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
      start = 1'b1; isStore = st; funct3 = f3; addr = a; storeData = d;
   endtask

   task automatic test_reset();
      tick(); tick();
      checks++; if (stall !== 1'b0)          begin failures++; $display("FAIL rst_stall got=%h exp=0", stall); end
      checks++; if (memReq !== 1'b0)         begin failures++; $display("FAIL rst_req got=%h exp=0", memReq); end
      checks++; if ({done, fault} !== 2'b00) begin failures++; $display("FAIL rst_done_fault got=%b exp=00", {done, fault}); end
      checks++; if (memByteEn !== 4'h0)      begin failures++; $display("FAIL rst_be got=%h exp=0", memByteEn); end
      checks++; if (memAddr !== 32'h0)       begin failures++; $display("FAIL rst_addr got=%h exp=0", memAddr); end
      checks++; if (loadData !== 32'h0)      begin failures++; $display("FAIL rst_ld got=%h exp=0", loadData); end
      checks++; if (faultCause !== 2'b00)    begin failures++; $display("FAIL rst_cause got=%h exp=0", faultCause); end
      rst = 1'b0; memAck = 1'b1;
      tick();
      checks++; if ({done, memReq} !== 2'b00) begin failures++; $display("FAIL idle_ack_ignored got=%b exp=00", {done, memReq}); end
      memAck = 1'b0;
   endtask

   task automatic test_lw();
      issue(1'b0, 3'b010, 32'h100, 32'h0);
      #1;
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL lw_stall_c0 got=%h exp=1", stall); end
      tick();
      start = 1'b0; memAck = 1'b1; memRdata = 32'hDEADBEEF;
      #1;
      checks++; if ({memReq, memWe, stall} !== 3'b101) begin failures++; $display("FAIL lw_req_c1 got=%b exp=101", {memReq, memWe, stall}); end
      checks++; if (memAddr !== 32'h100)  begin failures++; $display("FAIL lw_addr got=%h exp=100", memAddr); end
      checks++; if (memByteEn !== 4'hF)   begin failures++; $display("FAIL lw_be got=%h exp=f", memByteEn); end
      checks++; if (memWdata !== 32'h0)   begin failures++; $display("FAIL lw_wdata got=%h exp=0", memWdata); end
      tick();
      memAck = 1'b0;
      checks++; if ({done, stall, memReq} !== 3'b100) begin failures++; $display("FAIL lw_done_c2 got=%b exp=100", {done, stall, memReq}); end
      checks++; if (loadData !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_data got=%h exp=deadbeef", loadData); end
      tick();
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL lw_done_pulse got=%h exp=0", done); end
   endtask

   task automatic test_lb_lbu();
      issue(1'b0, 3'b000, 32'h103, 32'h0);
      tick();
      start = 1'b0; memAck = 1'b1; memRdata = 32'h80123456;
      checks++; if (memAddr !== 32'h100) begin failures++; $display("FAIL lb_addr got=%h exp=100", memAddr); end
      checks++; if (memByteEn !== 4'h8)  begin failures++; $display("FAIL lb_be got=%h exp=8", memByteEn); end
      tick();
      memAck = 1'b0;
      checks++; if (loadData !== 32'hFFFFFF80) begin failures++; $display("FAIL lb_data got=%h exp=ffffff80", loadData); end
      tick();
      issue(1'b0, 3'b100, 32'h103, 32'h0);
      tick();
      start = 1'b0; memAck = 1'b1;
      checks++; if (memReq !== 1'b1) begin failures++; $display("FAIL lbu_accept got=%h exp=1", memReq); end
      tick();
      memAck = 1'b0;
      checks++; if ({done, loadData} !== {1'b1, 32'h00000080}) begin failures++; $display("FAIL lbu_data got=%h/%h exp=1/00000080", done, loadData); end
      tick();
   endtask

   task automatic test_sh();
      issue(1'b1, 3'b001, 32'h202, 32'h1234ABCD);
      tick();
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++; if ({memReq, memWe, memByteEn} !== 6'b11_1100) begin failures++; $display("FAIL sh_ctl_%0d got=%b exp=111100", i, {memReq, memWe, memByteEn}); end
         checks++; if (memWdata !== 32'hABCDABCD) begin failures++; $display("FAIL sh_wdata_%0d got=%h exp=abcdabcd", i, memWdata); end
         checks++; if ({memAddr, done} !== {32'h200, 1'b0}) begin failures++; $display("FAIL sh_addr_%0d got=%h/%h exp=200/0", i, memAddr, done); end
         if (i == 2) memAck = 1'b1;
         tick();
      end
      memAck = 1'b0;
      checks++; if ({done, memReq} !== 2'b10) begin failures++; $display("FAIL sh_done got=%b exp=10", {done, memReq}); end
      checks++; if (loadData !== 32'h00000080) begin failures++; $display("FAIL sh_ld_kept got=%h exp=00000080", loadData); end
      tick();
   endtask

   task automatic test_faults();
      issue(1'b0, 3'b010, 32'h102, 32'h0);
      #1;
      checks++; if ({stall, memReq} !== 2'b10) begin failures++; $display("FAIL mis_c0 got=%b exp=10", {stall, memReq}); end
      tick();
      start = 1'b0;
      checks++; if ({fault, stall, memReq} !== 3'b100) begin failures++; $display("FAIL mis_c1 got=%b exp=100", {fault, stall, memReq}); end
      checks++; if (faultCause !== 2'b01) begin failures++; $display("FAIL mis_cause got=%b exp=01", faultCause); end
      tick();
      checks++; if ({fault, memReq, faultCause} !== 4'b0001) begin failures++; $display("FAIL mis_after got=%b exp=0001", {fault, memReq, faultCause}); end
      issue(1'b1, 3'b100, 32'h100, 32'h0);
      tick();
      start = 1'b0; isStore = 1'b0;
      checks++; if ({fault, memReq, faultCause} !== 4'b1010) begin failures++; $display("FAIL ill_store got=%b exp=1010", {fault, memReq, faultCause}); end
      tick();
   endtask

   task automatic test_timeout();
      issue(1'b0, 3'b010, 32'h300, 32'h0);
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++; if ({memReq, fault} !== 2'b10) begin failures++; $display("FAIL to_req_%0d got=%b exp=10", i, {memReq, fault}); end
         tick();
      end
      checks++; if ({fault, memReq, faultCause} !== 4'b1011) begin failures++; $display("FAIL to_fault got=%b exp=1011", {fault, memReq, faultCause}); end
      tick();
      issue(1'b0, 3'b010, 32'h104, 32'h0);
      tick();
      start = 1'b0; memAck = 1'b1; memRdata = 32'h11223344;
      tick();
      memAck = 1'b0;
      checks++; if ({done, fault, loadData} !== {2'b10, 32'h11223344}) begin failures++; $display("FAIL to_recover got=%b/%h exp=10/11223344", {done, fault}, loadData); end
      tick();
   endtask

   task automatic test_ack_at_limit();
      issue(1'b0, 3'b010, 32'h108, 32'h0);
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) begin memAck = 1'b1; memRdata = 32'hCAFEF00D; end
         tick();
      end
      memAck = 1'b0;
      checks++; if ({done, fault, loadData} !== {2'b10, 32'hCAFEF00D}) begin failures++; $display("FAIL ack_limit got=%b/%h exp=10/cafef00d", {done, fault}, loadData); end
      tick();
   endtask

   task automatic test_rst_mid();
      issue(1'b0, 3'b010, 32'h10C, 32'h0);
      tick();
      issue(1'b0, 3'b000, 32'h201, 32'h0);
      tick();
      checks++; if ({memReq, memAddr, memByteEn} !== {1'b1, 32'h10C, 4'hF}) begin failures++; $display("FAIL req_start_ignored got=%h/%h/%h exp=1/10c/f", memReq, memAddr, memByteEn); end
      start = 1'b0;
      #2 rst = 1'b1;
      #1;
      checks++; if ({memReq, stall, memByteEn} !== 6'b0) begin failures++; $display("FAIL rst_async got=%b exp=000000", {memReq, stall, memByteEn}); end
      tick();
      rst = 1'b0; memAck = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++; if ({done, fault, memReq} !== 3'b000) begin failures++; $display("FAIL rst_quiet_%0d got=%b exp=000", i, {done, fault, memReq}); end
      end
      memAck = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; isStore = 1'b0; funct3 = 3'b000; addr = '0;
      storeData = '0; memAck = 1'b0; memRdata = '0;
      test_reset();
      test_lw();
      test_lb_lbu();
      test_sh();
      test_faults();
      test_timeout();
      test_ack_at_limit();
      test_rst_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
